output_mems: RTL
================

# output_mems

Result-side buffer for the matrix-multiply accelerator: captures the M×N product matrix C, written element by element by the compute stage, then streams it out as an AXI-Stream master in row-major order. It mirrors `input_mems` on the other side of the datapath. `input_mems` loads A/B from AXIS; `output_mems` drains C to AXIS. The handshake with compute uses `compute_finished`; the handshake with the downstream consumer uses `AXIS_TVALID`/`AXIS_TREADY`/`AXIS_TLAST`.

## Interface
- `OUTW`, 24: width of one C element (signed, two's complement).
- `M`, 7: rows of C.
- `N`, 9: columns of C.
- `C_ADDR_BITS` (localparam), `$clog2(M*N)`: C address width.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `reset`  in  1  synchronous, active-low; block is reset on any posedge where `reset==0`.
- `C_wr_en`  in  1  write strobe from compute.
- `C_wr_addr`  in  C_ADDR_BITS  row-major index, row*N+col.
- `C_wr_data`  in  OUTW  element value.
- `compute_finished`  in  1  single-cycle pulse; C fully written.
- `C_ready`  out  1  high when the block accepts writes and `compute_finished`.
- `AXIS_TDATA`  out  OUTW  streamed element.
- `AXIS_TVALID`  out  1  master valid.
- `AXIS_TREADY`  in  1  slave ready.
- `AXIS_TLAST`  out  1  high with element M*N-1.

## Operation
- States (enum): `LOAD`, `DRAIN`.
- `LOAD`:
  - `C_ready=1`, `AXIS_TVALID=0`.
  - `C_wr_en` writes `C_wr_data` to `C_wr_addr`; writes with `C_wr_addr >= M*N` are ignored.
  - `compute_finished=1` → `DRAIN`. A write in the same cycle is still committed.
- `DRAIN`:
  - `C_ready=0`. `C_wr_en` and `compute_finished` are ignored.
  - Read counter `rd_addr` runs 0..M*N-1. Output counter `out_cnt` counts handshakes.
  - A RAM read is issued only when the 2-entry output buffer will have a free slot on the cycle the read data returns.
- Handshake:
  - Transfer occurs on a cycle with `TVALID && TREADY`.
  - While `TVALID && !TREADY`, `TDATA`/`TLAST` are held stable and `TVALID` stays high.
  - `TVALID` never depends combinationally on `TREADY`.
- `AXIS_TLAST=1` only when `out_cnt==M*N-1`.
- The transfer of the last element moves the block to `LOAD` on the next edge; `C_ready=1` in that cycle.
- Memory contents are not cleared between matrices. Unwritten locations stream stale data; this is the compute stage's responsibility.
- Counters wrap to 0 only via the return to `LOAD`, never mid-drain.

## Timing
- Values after a reset edge:
  - state `LOAD`, `C_ready=1`
  - `AXIS_TVALID=0`, `AXIS_TLAST=0`, `AXIS_TDATA=0`
  - counters 0, buffer empty
- Reset mid-drain: the above values take effect on the next edge. The partial stream is abandoned and no `TLAST` is sent.
- RAM read latency is 1 cycle (registered `data_out`).
- Latency: `compute_finished` sampled at edge t → `TVALID` first high after edge t+2.
- With `TREADY` held high, the stream has no bubbles: M*N transfers in M*N consecutive cycles.
- `TREADY` low for any number of cycles: no data lost or duplicated. Data resumes from the held element the cycle `TREADY` rises.
- Write in the same cycle as `compute_finished`: it is visible in the stream.

## Structure
- Shared package `output_mems_pkg`:
  - `state_t` enum {`LOAD`, `DRAIN`}.
  - Address-width helper function used by `input_mems`, `output_mems` and compute.
- Sub-module: reuse the codebase's single-port `memory` (WIDTH=OUTW, SIZE=M*N). The RAM address is muxed between `C_wr_addr` (`LOAD`) and `rd_addr` (`DRAIN`).
- The 2-entry output buffer (skid) is inline: data/last registers plus occupancy count.

## Test plan
- M=2, N=3, write C = 1..6 to addrs 0..5, pulse `compute_finished`, `TREADY=1` → `TDATA` 1,2,3,4,5,6 on 6 consecutive cycles, first 2 cycles after pulse, `TLAST` only with 6, `C_ready` back to 1 next cycle.
- Same data, `TREADY` toggling 1,0,0,1,0,1… → exact sequence 1..6, `TDATA` stable during every stall, no duplicates.
- Write to addr 6 (out of range) with value 0xABCDEF, then stream → six elements unchanged, addr-0 value not corrupted.
- During `DRAIN`, drive `C_wr_en=1` at addr 2 with -1, and a second `compute_finished` → stream unaffected, single `TLAST`, no second drain.
- Reset (`reset=0`) after 3 transfers → next cycle `TVALID=0`, `C_ready=1`. A new load of 10..15 streams 10..15 from element 0.
- Write addr 5 with 77 in the same cycle as `compute_finished` → last element 77 with `TLAST`.

Source files
------------

// File: rtl/output_mems_pkg.sv
// Shared definitions for the result-side buffer of the matrix-multiply
// accelerator: drain FSM states, default geometry and the address-width
// helper used by input_mems, output_mems and the compute stage.
package output_mems_pkg;

  // Buffer phase: LOAD accepts C writes, DRAIN streams C out over AXIS.
  typedef enum logic {
    LOAD,
    DRAIN
  } state_t;

  // Default geometry of the C matrix and its element width.
  localparam int DEF_OUTW = 24;
  localparam int DEF_M    = 7;
  localparam int DEF_N    = 9;

  // Address bits needed to index 'depth' entries; never less than one bit
  // so a degenerate 1-entry memory still has a legal address port.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : output_mems_pkg

// File: rtl/output_mems_memory.sv
// Single-port synchronous RAM with a registered read port (1-cycle read
// latency). Read-first: a write and a read to the same address in one
// cycle return the old contents.
module memory
  import output_mems_pkg::*;
#(
  parameter  int WIDTH     = DEF_OUTW,
  parameter  int SIZE      = DEF_M * DEF_N,
  localparam int ADDR_BITS = addr_bits(SIZE)
) (
  input  logic                 clk,
  input  logic                 i_wr_en,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [WIDTH-1:0]     i_wr_data,
  output logic [WIDTH-1:0]     o_rd_data
);

  logic [WIDTH-1:0] r_mem [SIZE];
  logic [WIDTH-1:0] r_rd_data;

  // Write port and registered read port sharing one address.
  // NOTE: the array and its read register carry no reset so they map onto
  // block RAM; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule : memory

// File: rtl/output_mems.sv
// Result-side buffer: captures the M x N product matrix C written element by
// element by the compute stage, then streams it out row-major as an
// AXI-Stream master. A 2-entry skid buffer behind the 1-cycle RAM keeps the
// stream bubble-free while TREADY is high and loses nothing while it is low.
module output_mems
  import output_mems_pkg::*;
#(
  parameter  int OUTW        = DEF_OUTW,
  parameter  int M           = DEF_M,
  parameter  int N           = DEF_N,
  localparam int C_ADDR_BITS = addr_bits(M * N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   C_wr_en,
  input  logic [C_ADDR_BITS-1:0] C_wr_addr,
  input  logic [OUTW-1:0]        C_wr_data,
  input  logic                   compute_finished,
  output logic                   C_ready,
  output logic [OUTW-1:0]        AXIS_TDATA,
  output logic                   AXIS_TVALID,
  input  logic                   AXIS_TREADY,
  output logic                   AXIS_TLAST
);

  localparam int                     DEPTH     = M * N;
  localparam logic [C_ADDR_BITS:0]   DEPTH_EXT = (C_ADDR_BITS + 1)'(DEPTH);
  localparam logic [C_ADDR_BITS-1:0] LAST_ADDR = C_ADDR_BITS'(DEPTH - 1);
  localparam logic [C_ADDR_BITS-1:0] ADDR_ONE  = C_ADDR_BITS'(1);

  // FSM
  state_t r_state;
  state_t w_state_next;

  // RAM port
  logic                   w_mem_we;
  logic [C_ADDR_BITS-1:0] w_mem_addr;
  logic [OUTW-1:0]        w_mem_rdata;

  // Read side: next address to fetch and the read currently in the RAM pipe
  logic [C_ADDR_BITS-1:0] r_rd_addr;
  logic                   r_rd_done;
  logic                   r_rd_valid;
  logic                   r_rd_last;
  logic                   w_issue;

  // Output side: handshake counter and the 2-entry skid buffer
  logic [C_ADDR_BITS-1:0] r_out_cnt;
  logic [1:0]             r_count;
  logic [OUTW-1:0]        r_q_data [2];
  logic                   r_q_last [2];

  logic                   w_valid;
  logic                   w_push;
  logic                   w_pop;
  logic [1:0]             w_count_next;
  logic [1:0]             w_base;
  logic                   w_wr_slot;
  logic                   w_drain_done;
  logic                   w_c_ready;

  // Skid-buffer bookkeeping. Occupancy after this edge decides whether a
  // read issued now still finds a free slot when its data lands one cycle
  // later, even if no pop happens in between.
  assign w_valid      = (r_count != 2'd0);
  assign w_pop        = w_valid && AXIS_TREADY;
  assign w_push       = r_rd_valid;
  assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_base       = w_pop ? (r_count - 2'd1) : r_count;
  assign w_wr_slot    = w_base[0];
  assign w_drain_done = w_pop && (r_out_cnt == LAST_ADDR);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode, C_ready, RAM address/write mux and read issue.
  // NOTE: every signal gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_c_ready    = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = C_wr_addr;
    w_issue      = 1'b0;
    case (r_state)
      LOAD: begin
        w_c_ready = 1'b1;
        // Out-of-range addresses are dropped rather than aliased.
        w_mem_we  = C_wr_en && ({1'b0, C_wr_addr} < DEPTH_EXT);
        if (compute_finished) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        w_mem_addr = r_rd_addr;
        w_issue    = !r_rd_done && (w_count_next <= 2'd1);
        if (w_drain_done) begin
          w_state_next = LOAD;
        end
      end
    endcase
  end

  memory #(
    .WIDTH (OUTW),
    .SIZE  (DEPTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_mem_we),
    .i_addr    (w_mem_addr),
    .i_wr_data (C_wr_data),
    .o_rd_data (w_mem_rdata)
  );

  // Read and handshake counters; both return to 0 only when the last
  // element is accepted (or on reset), never by wrapping mid-drain.
  always_ff @(posedge clk) begin
    if (!reset || w_drain_done) begin
      r_rd_addr  <= '0;
      r_rd_done  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_out_cnt  <= '0;
    end else begin
      r_rd_valid <= w_issue;
      r_rd_last  <= w_issue && (r_rd_addr == LAST_ADDR);
      if (w_issue) begin
        if (r_rd_addr == LAST_ADDR) begin
          r_rd_done <= 1'b1;
        end else begin
          r_rd_addr <= r_rd_addr + ADDR_ONE;
        end
      end
      if (w_pop) begin
        r_out_cnt <= r_out_cnt + ADDR_ONE;
      end
    end
  end

  // Skid buffer: slot 0 is the presented element; a pop shifts slot 1 down
  // and returning RAM data fills the first free slot after that shift.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count     <= 2'd0;
      r_q_data[0] <= '0;
      r_q_data[1] <= '0;
      r_q_last[0] <= 1'b0;
      r_q_last[1] <= 1'b0;
    end else if (w_drain_done) begin
      r_count <= 2'd0;
    end else begin
      r_count <= w_count_next;
      if (w_pop) begin
        r_q_data[0] <= r_q_data[1];
        r_q_last[0] <= r_q_last[1];
      end
      if (w_push) begin
        r_q_data[w_wr_slot] <= w_mem_rdata;
        r_q_last[w_wr_slot] <= r_rd_last;
      end
    end
  end

  assign C_ready     = w_c_ready;
  assign AXIS_TVALID = w_valid;
  assign AXIS_TDATA  = r_q_data[0];
  assign AXIS_TLAST  = w_valid && r_q_last[0];

endmodule : output_mems
